// File: rtl/csr_file.sv
// csr_file -- machine-mode CSR file for the RV32 core.
//
// Implements mstatus (MIE/MPIE, MPP fixed to M), misa, mie/mip with NUM_IRQ
// level-sensitive platform lines at bits [16+NUM_IRQ-1:16], a WARL mtvec
// with vectored target computation, mscratch, mepc, mcause, and 64-bit
// mcycle/minstret with read-only shadows at 0xC00/0xC80/0xC02/0xC82.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   we, a, di       main port: write enable, CSR address, write data
//   dout            combinational read of the CSR at a ("do" is a reserved
//                   word in SystemVerilog, so the read port is named dout)
//   illegal         unknown CSR address, or a write to a read-only (a[11:10]=11) CSR
//   trap, trapCause, trapPc   trap-entry strobe with mcause/mepc values
//   mret, retire    mret strobe, instruction-retired strobe
//   irq             level interrupt lines
//   irqPending      mstatus.MIE & |(mip & mie)
//   irqCause        interrupt cause of the lowest pending enabled line, 0 if none
//   trapVector      trap target PC for the current trapCause
//   mepcDo          current mepc
//
// Simultaneous events: trap beats mret, and both strobes beat a main-port
// write to mstatus; trap beats a main-port write to mepc.
module csr_file #(
    parameter int          NUM_IRQ      = 4,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [11:0]        a,
    input  logic [31:0]        di,
    output logic [31:0]        dout,
    output logic               illegal,
    input  logic               trap,
    input  logic [31:0]        trapCause,
    input  logic [31:0]        trapPc,
    input  logic               mret,
    input  logic               retire,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               irqPending,
    output logic [31:0]        irqCause,
    output logic [31:0]        trapVector,
    output logic [31:0]        mepcDo
);

    logic               mstatusMie;
    logic               mstatusMpie;
    logic [NUM_IRQ-1:0] mieIrq;
    logic [31:0]        mtvec;
    logic [31:0]        mscratch;
    logic [31:0]        mepc;
    logic [31:0]        mcause;
    logic [63:0]        mcycle;
    logic [63:0]        minstret;

    logic [31:0] mipWord;
    logic [31:0] mieWord;
    logic        implemented;
    logic        writeOk;
    logic [63:0] cycleInc;
    logic [63:0] instInc;
    logic [31:0] tvecBase;

    // Read-only CSRs live at a[11:10] = 2'b11; writes there never land.
    assign writeOk = we && (a[11:10] != 2'b11);

    always_comb begin
        mipWord = '0;
        mieWord = '0;
        mipWord[16 +: NUM_IRQ] = irq;
        mieWord[16 +: NUM_IRQ] = mieIrq;
    end

    // Main read port
    always_comb begin
        dout        = '0;
        implemented = 1'b1;
        case (a)
            12'h300: dout = {19'd0, 2'b11, 3'd0, mstatusMpie, 3'd0, mstatusMie, 3'd0};
            12'h301: dout = 32'h4000_0100;
            12'h304: dout = mieWord;
            12'h344: dout = mipWord;
            12'h305: dout = mtvec;
            12'h340: dout = mscratch;
            12'h341: dout = mepc;
            12'h342: dout = mcause;
            12'hB00, 12'hC00: dout = mcycle[31:0];
            12'hB80, 12'hC80: dout = mcycle[63:32];
            12'hB02, 12'hC02: dout = minstret[31:0];
            12'hB82, 12'hC82: dout = minstret[63:32];
            default: implemented = 1'b0;
        endcase
    end

    assign illegal    = !implemented || (we && a[11:10] == 2'b11);
    assign irqPending = mstatusMie && |(mipWord & mieWord);
    assign mepcDo     = mepc;

    // Lowest-numbered line wins: scan from the top so the last hit is the lowest.
    always_comb begin
        irqCause = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq[i] && mieIrq[i]) irqCause = {1'b1, 31'(16 + i)};
        end
    end

    // Vectored mode only offsets interrupts (trapCause[31] set).
    always_comb begin
        tvecBase = {mtvec[31:2], 2'b00};
        if (mtvec[1:0] == 2'b01 && trapCause[31])
            trapVector = tvecBase + {24'd0, trapCause[5:0], 2'b00};
        else
            trapVector = tvecBase;
    end

    // mstatus
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatusMie  <= 1'b0;
            mstatusMpie <= 1'b0;
        end else if (trap) begin
            mstatusMpie <= mstatusMie;
            mstatusMie  <= 1'b0;
        end else if (mret) begin
            mstatusMie  <= mstatusMpie;
            mstatusMpie <= 1'b1;
        end else if (writeOk && a == 12'h300) begin
            mstatusMie  <= di[3];
            mstatusMpie <= di[7];
        end
    end

    // Plain read/write CSRs and trap-captured mepc/mcause
    always_ff @(posedge clk) begin
        if (reset) begin
            mieIrq   <= '0;
            mtvec    <= MTVEC_RESET;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else begin
            if (writeOk && a == 12'h304) mieIrq <= di[16 +: NUM_IRQ];
            // WARL: only direct (00) and vectored (01) modes are accepted.
            if (writeOk && a == 12'h305 && !di[1]) mtvec <= di;
            if (writeOk && a == 12'h340) mscratch <= di;
            if (trap) begin
                mepc   <= {trapPc[31:2], 2'b00};
                mcause <= trapCause;
            end else if (writeOk && a == 12'h341) begin
                mepc <= {di[31:2], 2'b00};
            end
        end
    end

    // Counters: a written half takes the write data; the other half still
    // counts, but carry never crosses into a half written the same cycle.
    assign cycleInc = mcycle + 64'd1;
    assign instInc  = minstret + {63'd0, retire};

    always_ff @(posedge clk) begin
        if (reset || !HAS_COUNTERS) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (writeOk && a == 12'hB00)      mcycle <= {mcycle[63:32], di};
            else if (writeOk && a == 12'hB80) mcycle <= {di, cycleInc[31:0]};
            else                              mcycle <= cycleInc;

            if (writeOk && a == 12'hB02)      minstret <= {minstret[63:32], di};
            else if (writeOk && a == 12'hB82) minstret <= {di, instInc[31:0]};
            else                              minstret <= instInc;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

    localparam int          NIRQ  = 4;
    localparam logic [31:0] TVRST = 32'h0000_0100;

    // Clock / reset / DUT signals
    logic            clk = 1'b0;
    logic            reset;
    logic            we;
    logic [11:0]     a;
    logic [31:0]     di;
    logic [31:0]     dout;
    logic            illegal;
    logic            trap;
    logic [31:0]     trapCause;
    logic [31:0]     trapPc;
    logic            mret;
    logic            retire;
    logic [NIRQ-1:0] irq;
    logic            irqPending;
    logic [31:0]     irqCause;
    logic [31:0]     trapVector;
    logic [31:0]     mepcDo;

    always #5 clk = ~clk;

    csr_file #(.NUM_IRQ(NIRQ), .MTVEC_RESET(TVRST), .HAS_COUNTERS(1'b1)) dut (
        .clk(clk), .reset(reset), .we(we), .a(a), .di(di), .dout(dout),
        .illegal(illegal), .trap(trap), .trapCause(trapCause), .trapPc(trapPc),
        .mret(mret), .retire(retire), .irq(irq), .irqPending(irqPending),
        .irqCause(irqCause), .trapVector(trapVector), .mepcDo(mepcDo)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: architectural values of each CSR.
    bit              m_mie, m_mpie;
    logic [NIRQ-1:0] m_ie;
    logic [31:0]     m_mtvec, m_scratch, m_mepc, m_mcause;
    logic [63:0]     m_cyc, m_ins;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] addr);
        case (addr)
            12'h300: return 32'h1800 + (m_mie ? 32'd8 : 32'd0) + (m_mpie ? 32'd128 : 32'd0);
            12'h301: return 32'h4000_0100;
            12'h304: return 32'(m_ie) << 16;
            12'h344: return 32'(irq) << 16;
            12'h305: return m_mtvec;
            12'h340: return m_scratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_illegal(input logic [11:0] addr, input bit wen);
        bit known;
        known = (addr inside {12'h300, 12'h301, 12'h304, 12'h344, 12'h305, 12'h340,
                              12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                              12'hC00, 12'hC80, 12'hC02, 12'hC82});
        return !known || (wen && addr >= 12'hC00);
    endfunction

    function automatic logic [31:0] m_irq_cause();
        for (int i = 0; i < NIRQ; i++)
            if (irq[i] && m_ie[i]) return 32'h8000_0000 + 32'(16 + i);
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_tvec();
        logic [31:0] base;
        base = m_mtvec & ~32'd3;
        if ((m_mtvec & 32'd3) == 32'd1 && trapCause[31])
            return base + (trapCause & 32'd63) * 32'd4;
        return base;
    endfunction

    // Apply one clock edge's worth of architectural effects to the model.
    task automatic model_edge();
        bit          old_mie, old_mpie, wr_ok;
        logic [63:0] c, r;
        if (reset) begin
            m_mie = 0; m_mpie = 0; m_ie = '0; m_mtvec = TVRST;
            m_scratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
            return;
        end
        old_mie  = m_mie;
        old_mpie = m_mpie;
        wr_ok    = we && (a < 12'hC00);
        c = m_cyc + 64'd1;
        r = m_ins + (retire ? 64'd1 : 64'd0);
        if (wr_ok && a == 12'hB00)      c = {m_cyc[63:32], di};
        else if (wr_ok && a == 12'hB80) c = {di, c[31:0]};
        if (wr_ok && a == 12'hB02)      r = {m_ins[63:32], di};
        else if (wr_ok && a == 12'hB82) r = {di, r[31:0]};
        m_cyc = c;
        m_ins = r;
        if (wr_ok) begin
            case (a)
                12'h300: begin m_mie = di[3]; m_mpie = di[7]; end
                12'h304: m_ie = di[16 +: NIRQ];
                12'h305: if ((di & 32'd3) <= 32'd1) m_mtvec = di;
                12'h340: m_scratch = di;
                12'h341: m_mepc = di & ~32'd3;
                default: ;
            endcase
        end
        if (trap) begin
            m_mepc   = trapPc & ~32'd3;
            m_mcause = trapCause;
            m_mpie   = old_mie;
            m_mie    = 0;
        end else if (mret) begin
            m_mie  = old_mpie;
            m_mpie = 1;
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd(input logic [11:0] addr);
        we = 1'b0;
        a  = addr;
        #1;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        we = 1'b1; a = addr; di = data;
        tick();
        we = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_do"},      dout, m_read(a));
        chk({tag, "_illegal"}, 32'(illegal), 32'(m_illegal(a, we)));
        chk({tag, "_pend"},    32'(irqPending), 32'(m_mie && ((irq & m_ie) != '0)));
        chk({tag, "_cause"},   irqCause, m_irq_cause());
        chk({tag, "_tvec"},    trapVector, m_tvec());
        chk({tag, "_mepc"},    mepcDo, m_mepc);
    endtask

    logic [11:0] addr_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h344, 12'h305, 12'h340,
                                   12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                   12'hC00, 12'hC80, 12'hC02, 12'hC82};

    initial begin
        logic [31:0] v;
        reset = 1; we = 0; a = 0; di = 0; trap = 0; trapCause = 0; trapPc = 0;
        mret = 0; retire = 0; irq = '0;
        tick(); tick();

        // Reset state (reset still asserted, so counters hold at 0)
        rd(12'h305); chk("rst_mtvec", dout, 32'h100);
        rd(12'h300); chk("rst_mstatus", dout, 32'h1800);
        rd(12'h341); chk("rst_mepc", dout, 32'h0);
        rd(12'h342); chk("rst_mcause", dout, 32'h0);
        rd(12'h304); chk("rst_mie", dout, 32'h0);
        rd(12'hB00); chk("rst_mcycle", dout, 32'h0);
        chk("rst_pend", 32'(irqPending), 32'd0);
        reset = 0;

        // mtvec WARL and vectored target
        wr(12'h305, 32'h200); rd(12'h305); chk("mtvec_200", dout, 32'h200);
        wr(12'h305, 32'h2FE); rd(12'h305); chk("mtvec_drop", dout, 32'h200);
        wr(12'h305, 32'h201); rd(12'h305); chk("mtvec_201", dout, 32'h201);
        trapCause = 32'h8000_0013; #1;
        chk("tvec_vectored", trapVector, 32'h24C);
        trapCause = 32'd11; #1;
        chk("tvec_exception", trapVector, 32'h200);

        // Interrupt pending / cause
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h0002_0000);
        irq = 4'b1010; #1;
        chk("irq_pend", 32'(irqPending), 32'd1);
        chk("irq_cause", irqCause, 32'h8000_0011);
        wr(12'h304, 32'h0);
        chk("irq_pend_off", 32'(irqPending), 32'd0);
        irq = '0;

        // Trap entry then mret
        trapPc = 32'h87; trapCause = 32'd11; trap = 1;
        tick();
        trap = 0;
        rd(12'h341); chk("trap_mepc", dout, 32'h84);
        chk("trap_mepcDo", mepcDo, 32'h84);
        rd(12'h342); chk("trap_mcause", dout, 32'd11);
        rd(12'h300); chk("trap_mstatus", dout, 32'h1880);
        mret = 1; tick(); mret = 0;
        rd(12'h300); chk("mret_mstatus", dout, 32'h1888);

        // Counter carry and minstret
        wr(12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        tick(); tick();
        rd(12'hB80); chk("cyc_hi", dout, 32'h1);
        rd(12'hB00); chk("cyc_lo", dout, 32'h1);
        retire = 1; tick(); tick(); tick(); retire = 0;
        rd(12'hB02); chk("instret_lo", dout, 32'h3);
        rd(12'hC02); chk("instret_shadow", dout, 32'h3);

        // Illegal accesses and ignored writes
        rd(12'h7C0);
        chk("ill_unimpl", 32'(illegal), 32'd1);
        chk("ill_do", dout, 32'h0);
        rd(12'hC00); v = dout;
        we = 1; a = 12'hC00; di = 32'h0; #1;
        chk("ill_ro_write", 32'(illegal), 32'd1);
        tick(); we = 0;
        rd(12'hC00); chk("ro_no_change", dout, v + 32'd1);
        we = 1; a = 12'h342; di = 32'h5; #1;
        chk("mcause_wr_legal", 32'(illegal), 32'd0);
        tick(); we = 0;
        rd(12'h342); chk("mcause_wr_ignored", dout, 32'd11);
        we = 1; a = 12'h301; di = 32'h0; #1;
        chk("misa_wr_legal", 32'(illegal), 32'd0);
        tick(); we = 0;

        // Randomized phase against the model
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            we        = ($urandom_range(0, 2) != 0);
            a         = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(0, 4095))
                                                    : addr_tab[$urandom_range(0, 15)];
            di        = $urandom;
            trap      = ($urandom_range(0, 7) == 0);
            mret      = ($urandom_range(0, 7) == 0);
            retire    = 1'($urandom_range(0, 1));
            irq       = NIRQ'($urandom);
            trapCause = {1'($urandom_range(0, 1)), 31'($urandom)};
            trapPc    = $urandom;
            #1;
            check_all("rand");
            tick();
        end
        reset = 0; we = 0; trap = 0; mret = 0; retire = 0;

        // Final sweep of every implemented CSR
        for (int i = 0; i < 16; i++) begin
            rd(addr_tab[i]);
            chk("sweep", dout, m_read(addr_tab[i]));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
